// File: rtl/regfile_pkg.sv
// Shared widths and types for the register file and its pending-write scoreboard.
package regfile_pkg;
   localparam int N      = 32;
   localparam int REGS   = 32;
   localparam int ADDR_W = $clog2(REGS);
   localparam int CNT_W  = 2;

   typedef logic [ADDR_W-1:0] reg_addr_t;
   typedef logic [N-1:0]      word_t;
   typedef logic [CNT_W-1:0]  cnt_t;

   localparam cnt_t CNT_MAX = '1;
   localparam cnt_t CNT_ONE = cnt_t'(1);
endpackage

// File: rtl/regfile_scoreboard_sb_counter.sv
// Saturating per-register in-flight write counter; o_err is sticky on overflow or underflow.
module sb_counter
   import regfile_pkg::*;
(
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_inc,
   input  logic i_dec,
   input  logic i_clr,
   output cnt_t o_cnt,
   output logic o_err
);
   cnt_t r_cnt;
   logic r_err;

   // clr drops any simultaneous dec; inc is already masked by the caller during clr
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
         r_err <= 1'b0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && !i_dec) begin
         if (r_cnt == CNT_MAX) r_err <= 1'b1;
         else                  r_cnt <= r_cnt + CNT_ONE;
      end else if (i_dec && !i_inc) begin
         if (r_cnt == '0) r_err <= 1'b1;
         else             r_cnt <= r_cnt - CNT_ONE;
      end
   end

   assign o_cnt = r_cnt;
   assign o_err = r_err;
endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with async reads plus per-register pending-write counters driving busy/stall.
// Reads and busy/stall are zero-latency; commits land at the next edge and are never blocked.
module regfile_scoreboard
   import regfile_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] rs_ID,
   input  logic [ADDR_W-1:0] rt_ID,
   input  logic              use_rs,
   input  logic              use_rt,
   output logic [N-1:0]      read_data_1,
   output logic [N-1:0]      read_data_2,
   input  logic              issue_en,
   input  logic [ADDR_W-1:0] issue_addr,
   input  logic              regfile_write_en,
   input  logic [ADDR_W-1:0] write_addr,
   input  logic [N-1:0]      write_data,
   input  logic              flush,
   output logic              busy_rs,
   output logic              busy_rt,
   output logic              stall,
   output logic              issue_full,
   output logic              sb_error
);
   word_t            r_mem [REGS];
   cnt_t             w_cnt [REGS];
   logic [REGS-1:0]  w_err;
   logic             w_busy_rs;
   logic             w_busy_rt;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < REGS; i++) r_mem[i] <= '0;
      end else if (regfile_write_en && write_addr != '0) begin
         r_mem[write_addr] <= write_data;
      end
   end

   assign w_cnt[0] = '0;
   assign w_err[0] = 1'b0;

   genvar r;
   generate
      for (r = 1; r < REGS; r++) begin : g_cnt
         logic w_inc;
         logic w_dec;
         assign w_inc = issue_en && (issue_addr == reg_addr_t'(r)) && !flush;
         assign w_dec = regfile_write_en && (write_addr == reg_addr_t'(r));
         sb_counter u_cnt (
            .i_clk (clk),
            .i_rst (rst),
            .i_inc (w_inc),
            .i_dec (w_dec),
            .i_clr (flush),
            .o_cnt (w_cnt[r]),
            .o_err (w_err[r])
         );
      end
   endgenerate

   // a last outstanding write committing this cycle is covered by the ID-stage bypass
   assign w_busy_rs = (rs_ID != '0) &&
                      ((w_cnt[rs_ID] > CNT_ONE) ||
                       ((w_cnt[rs_ID] == CNT_ONE) && !(regfile_write_en && write_addr == rs_ID)));
   assign w_busy_rt = (rt_ID != '0) &&
                      ((w_cnt[rt_ID] > CNT_ONE) ||
                       ((w_cnt[rt_ID] == CNT_ONE) && !(regfile_write_en && write_addr == rt_ID)));

   assign busy_rs     = !rst && w_busy_rs;
   assign busy_rt     = !rst && w_busy_rt;
   assign stall       = (use_rs && busy_rs) || (use_rt && busy_rt);
   assign issue_full  = !rst && (issue_addr != '0) && (w_cnt[issue_addr] == CNT_MAX);
   assign read_data_1 = (rst || rs_ID == '0) ? '0 : r_mem[rs_ID];
   assign read_data_2 = (rst || rt_ID == '0) ? '0 : r_mem[rt_ID];
   assign sb_error    = |w_err;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed and random checks of regfile_scoreboard against an array-based reference model.
module tb_regfile_scoreboard;
   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  rs_ID, rt_ID, issue_addr, write_addr;
   logic        use_rs, use_rt, issue_en, regfile_write_en, flush;
   logic [31:0] write_data, read_data_1, read_data_2;
   logic        busy_rs, busy_rt, stall, issue_full, sb_error;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] m_mem [32];
   int          m_cnt [32];
   bit          m_err;

   regfile_scoreboard dut (
      .clk(clk), .rst(rst), .rs_ID(rs_ID), .rt_ID(rt_ID), .use_rs(use_rs), .use_rt(use_rt),
      .read_data_1(read_data_1), .read_data_2(read_data_2), .issue_en(issue_en),
      .issue_addr(issue_addr), .regfile_write_en(regfile_write_en), .write_addr(write_addr),
      .write_data(write_data), .flush(flush), .busy_rs(busy_rs), .busy_rt(busy_rt),
      .stall(stall), .issue_full(issue_full), .sb_error(sb_error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] m_rd(input int a);
      return (rst || a == 0) ? 32'h0 : m_mem[a];
   endfunction

   function automatic bit m_busy(input int a);
      if (rst || a == 0) return 1'b0;
      return (m_cnt[a] > 1) || (m_cnt[a] == 1 && !(regfile_write_en && int'(write_addr) == a));
   endfunction

   function automatic bit m_stall();
      return (use_rs && m_busy(int'(rs_ID))) || (use_rt && m_busy(int'(rt_ID)));
   endfunction

   function automatic bit m_full();
      return !rst && issue_addr != 0 && m_cnt[issue_addr] == 3;
   endfunction

   task automatic check_all(input string tag);
      #1;
      chk({tag, ".rd1"}, read_data_1, m_rd(int'(rs_ID)));
      chk({tag, ".rd2"}, read_data_2, m_rd(int'(rt_ID)));
      chk({tag, ".busy_rs"}, 32'(busy_rs), 32'(m_busy(int'(rs_ID))));
      chk({tag, ".busy_rt"}, 32'(busy_rt), 32'(m_busy(int'(rt_ID))));
      chk({tag, ".stall"}, 32'(stall), 32'(m_stall()));
      chk({tag, ".full"}, 32'(issue_full), 32'(m_full()));
      chk({tag, ".sb_error"}, 32'(sb_error), 32'(m_err));
   endtask

   task automatic model_update();
      bit inc, dec;
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            m_mem[i] = 32'h0;
            m_cnt[i] = 0;
         end
         m_err = 1'b0;
         return;
      end
      if (regfile_write_en && write_addr != 0) m_mem[write_addr] = write_data;
      if (flush) begin
         for (int i = 0; i < 32; i++) m_cnt[i] = 0;
         return;
      end
      inc = issue_en && issue_addr != 0;
      dec = regfile_write_en && write_addr != 0;
      if (inc && dec && issue_addr == write_addr) return;
      if (inc) begin
         if (m_cnt[issue_addr] == 3) m_err = 1'b1;
         else m_cnt[issue_addr]++;
      end
      if (dec) begin
         if (m_cnt[write_addr] == 0) m_err = 1'b1;
         else m_cnt[write_addr]--;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic idle();
      rst = 1'b0; flush = 1'b0; issue_en = 1'b0; regfile_write_en = 1'b0;
      use_rs = 1'b0; use_rt = 1'b0; issue_addr = 5'd0; write_addr = 5'd0;
      write_data = 32'h0; rs_ID = 5'd0; rt_ID = 5'd0;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      step();
      check_all("rst_hold");

      // T1: reset wipes data
      idle(); regfile_write_en = 1'b1; write_addr = 5'd5; write_data = 32'hDEAD; rs_ID = 5'd5;
      check_all("t1_wr"); step();
      idle(); rs_ID = 5'd5;
      check_all("t1_rd"); chk("t1_r5_written", read_data_1, 32'hDEAD); step();
      rst = 1'b1; check_all("t1_rst"); step();
      rst = 1'b0;
      check_all("t1_post");
      chk("t1_r5_cleared", read_data_1, 32'h0);
      chk("t1_busy", 32'(busy_rs), 32'h0);
      chk("t1_sb_error", 32'(sb_error), 32'h0);
      step();

      // T2: issue then commit r3
      idle(); issue_en = 1'b1; issue_addr = 5'd3; rs_ID = 5'd3; use_rs = 1'b1;
      check_all("t2_issue"); step();
      issue_en = 1'b0;
      check_all("t2_wait"); chk("t2_stall", 32'(stall), 32'h1); step();
      regfile_write_en = 1'b1; write_addr = 5'd3; write_data = 32'h1234;
      check_all("t2_commit"); chk("t2_busy_commit", 32'(busy_rs), 32'h0); step();
      regfile_write_en = 1'b0;
      check_all("t2_after"); chk("t2_rd", read_data_1, 32'h1234); step();

      // T3: saturate r7, overflow, drain
      idle(); issue_en = 1'b1; issue_addr = 5'd7; rs_ID = 5'd7;
      for (int i = 0; i < 3; i++) begin check_all("t3_issue"); step(); end
      issue_en = 1'b0;
      check_all("t3_full"); chk("t3_issue_full", 32'(issue_full), 32'h1);
      issue_en = 1'b1; check_all("t3_ovf"); step();
      issue_en = 1'b0;
      check_all("t3_err"); chk("t3_sb_error", 32'(sb_error), 32'h1);
      chk("t3_still_full", 32'(issue_full), 32'h1);
      regfile_write_en = 1'b1; write_addr = 5'd7;
      for (int i = 0; i < 3; i++) begin write_data = 32'h700 + 32'(i); check_all("t3_drain"); step(); end
      regfile_write_en = 1'b0;
      check_all("t3_done"); chk("t3_busy_clear", 32'(busy_rs), 32'h0);
      rst = 1'b1; step();

      // T4: simultaneous issue/commit with one outstanding keeps r9 pending
      idle(); issue_en = 1'b1; issue_addr = 5'd9; rs_ID = 5'd9;
      check_all("t4_issue"); step();
      regfile_write_en = 1'b1; write_addr = 5'd9; write_data = 32'h9999;
      check_all("t4_both"); step();
      issue_en = 1'b0; regfile_write_en = 1'b0;
      check_all("t4_after"); chk("t4_busy", 32'(busy_rs), 32'h1);
      chk("t4_no_err", 32'(sb_error), 32'h0); step();

      // T5: register 0 is inert
      idle(); regfile_write_en = 1'b1; write_addr = 5'd0; write_data = 32'hFFFF;
      issue_en = 1'b1; issue_addr = 5'd0; use_rs = 1'b1;
      check_all("t5_wr"); step();
      regfile_write_en = 1'b0; issue_en = 1'b0;
      check_all("t5_rd");
      chk("t5_r0", read_data_1, 32'h0); chk("t5_busy", 32'(busy_rs), 32'h0);
      chk("t5_stall", 32'(stall), 32'h0); chk("t5_err", 32'(sb_error), 32'h0);
      step();

      // T6: flush clears pending, then commit underflows
      idle(); issue_en = 1'b1; issue_addr = 5'd4; check_all("t6_i4"); step();
      issue_addr = 5'd6; check_all("t6_i6"); step();
      issue_addr = 5'd8; flush = 1'b1; check_all("t6_flush"); step();
      idle(); rs_ID = 5'd4; rt_ID = 5'd6; use_rs = 1'b1; use_rt = 1'b1;
      check_all("t6_post");
      chk("t6_busy4", 32'(busy_rs), 32'h0); chk("t6_busy6", 32'(busy_rt), 32'h0);
      rs_ID = 5'd9; rt_ID = 5'd8;
      check_all("t6_r8"); chk("t6_busy8", 32'(busy_rt), 32'h0);
      rs_ID = 5'd4; rt_ID = 5'd0;
      regfile_write_en = 1'b1; write_addr = 5'd4; write_data = 32'h4444;
      check_all("t6_commit"); step();
      regfile_write_en = 1'b0;
      check_all("t6_after"); chk("t6_data", read_data_1, 32'h4444);
      chk("t6_underflow", 32'(sb_error), 32'h1);
      rst = 1'b1; step();

      // random traffic on a small register window so hazards collide often
      for (int n = 0; n < 400; n++) begin
         rst              = ($urandom_range(0, 59) == 0);
         flush            = ($urandom_range(0, 24) == 0);
         rs_ID            = 5'($urandom_range(0, 7));
         rt_ID            = 5'($urandom_range(0, 7));
         use_rs           = 1'($urandom);
         use_rt           = 1'($urandom);
         regfile_write_en = 1'($urandom);
         write_addr       = 5'($urandom_range(0, 7));
         write_data       = $urandom;
         issue_addr       = 5'($urandom_range(0, 7));
         issue_en         = 1'b0;
         issue_en         = 1'($urandom) && !m_full() && !m_stall();
         check_all("rnd");
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
